multiplier_factor_seq: RTL and testbench
========================================

MULTIPLIER_FACTOR_SEQ -- requirements
Module: multiplier_factor_seq

Interface
REQ-001 SHALL have parameter A_W, default 7, width of factor a.
REQ-002 SHALL have parameter B_W, default 4, width of factor b and multiplier iteration count.
REQ-003 SHALL derive local P_W = A_W+B_W, the product and target width; not overridable.
REQ-004 SHALL have port clk  input  1  sole clock; all state updates on rising edge.
REQ-005 SHALL have port rst_n  input  1  reset, synchronous and active-low.
REQ-006 SHALL have port start  input  1  request; accepted only in IDLE.
REQ-007 SHALL have port mode  input  1  0 = CHECK given pair, 1 = SEARCH all pairs.
REQ-008 SHALL have port a  input  A_W  candidate factor, CHECK mode only.
REQ-009 SHALL have port b  input  B_W  candidate factor, CHECK mode only.
REQ-010 SHALL have port target  input  P_W  number to factorise.
REQ-011 SHALL have port abort  input  1  terminates SEARCH early.
REQ-012 SHALL have port busy  output  1  high in every non-IDLE state.
REQ-013 SHALL have port done  output  1  one-cycle completion pulse.
REQ-014 SHALL have port sat  output  1  nontrivial factorisation found; valid from done until next accepted start.
REQ-015 SHALL have ports found_a  output  A_W  and found_b  output  B_W  holding the satisfying pair, else zero.

Function
REQ-016 SHALL implement states IDLE, MUL, CMP, DONE.
REQ-017 On start in IDLE, SHALL latch mode and target; in CHECK, latch a, b; in SEARCH, init a=2, b=2; clear sat, found_a, found_b; go MUL.
REQ-018 MUL SHALL run exactly B_W cycles of shift-add (LSB of b first) into a P_W-bit accumulator; product SHALL be exact, no truncation.
REQ-019 CMP (1 cycle) SHALL evaluate hit = (product == target) && a >= 2 && b >= 2.
REQ-020 CHECK: CMP SHALL go to DONE; sat = hit; found_a/found_b = a/b if hit, else 0.
REQ-021 SEARCH: on hit, CMP SHALL go to DONE with sat=1 and the pair captured.
REQ-022 SEARCH order SHALL be b outer (2..2^B_W-1), a inner (2..2^A_W-1); on miss, CMP SHALL load the next pair and return to MUL without an extra cycle.
REQ-023 SEARCH miss on the final pair (a, b both all-ones) SHALL go to DONE with sat=0.
REQ-024 Pair cost SHALL be B_W+1 cycles; with start accepted at edge 0 and n the 1-based pair index, done SHALL be high in cycle n*(B_W+1)+1.
REQ-025 DONE SHALL assert done for one cycle and return to IDLE; busy low in that cycle.
REQ-026 start while busy SHALL be ignored; inputs a, b, target, mode SHALL not affect an operation in flight.
REQ-027 abort high during SEARCH in MUL or CMP SHALL go to DONE next edge with sat=0, found 0; abort SHALL take priority over a simultaneous hit; abort SHALL be ignored in CHECK and IDLE.
REQ-028 start and done SHALL not overlap; start in the DONE cycle SHALL be ignored.

Reset
REQ-029 rst_n low at a rising edge SHALL force IDLE and busy=0, done=0, sat=0, found_a=0, found_b=0, accumulator 0, from any state including mid-MUL.
REQ-030 After rst_n returns high, the first start SHALL behave identically to a start after power-up reset.

Verification
REQ-031 Defaults, CHECK, target=221, a=17, b=13 -> done in cycle 6, sat=1, found_a=17, found_b=13.
REQ-032 Defaults, CHECK, target=227, a=227 truncated/any, b=1 -> done cycle 6, sat=0 (b<2 rejected), found 0.
REQ-033 Defaults, SEARCH, target=221 -> sat=1, found_a=17, found_b=13 at pair n=1402, done in cycle 7011.
REQ-034 Defaults, SEARCH, target=227 (prime) -> done after n=1764 pairs (cycle 8821), sat=0, found 0.
REQ-035 SEARCH target=221, abort pulsed in cycle 100 -> done cycle 101, sat=0; start pulses while busy ignored.
REQ-036 rst_n low during MUL of a CHECK -> all outputs 0 next cycle; subsequent CHECK 17x13 vs 221 passes per REQ-031.

Source files
------------

// File: rtl/multiplier_factor_seq.sv
// Sequential factor checker/searcher: multiplies a candidate pair by shift-add and compares the
// product against a target, either for one given pair or scanning every pair in order.
module multiplier_factor_seq #(
  parameter int unsigned A_W = 7,
  parameter int unsigned B_W = 4
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 start,
  input  logic                 mode,
  input  logic [A_W-1:0]       a,
  input  logic [B_W-1:0]       b,
  input  logic [A_W+B_W-1:0]   target,
  input  logic                 abort,
  output logic                 busy,
  output logic                 done,
  output logic                 sat,
  output logic [A_W-1:0]       found_a,
  output logic [B_W-1:0]       found_b
);

  localparam int unsigned P_W  = A_W + B_W;
  localparam int unsigned CntW = $clog2(B_W + 1);

  typedef enum logic [1:0] {StIdle, StMul, StCmp, StDone} state_e;

  state_e          state_q;
  logic            mode_q;
  logic [P_W-1:0]  target_q;
  logic [A_W-1:0]  a_q;
  logic [B_W-1:0]  b_q;
  logic [P_W-1:0]  mcand_q;
  logic [B_W-1:0]  mplier_q;
  logic [P_W-1:0]  acc_q;
  logic [CntW-1:0] cnt_q;
  logic            busy_q, done_q, sat_q;
  logic [A_W-1:0]  found_a_q;
  logic [B_W-1:0]  found_b_q;

  logic            hit;
  logic            last_pair;
  logic [A_W-1:0]  next_a;
  logic [B_W-1:0]  next_b;

  // Search order: a runs fastest and wraps back to 2 while b advances.
  always_comb begin
    hit       = (acc_q == target_q) && (a_q >= A_W'(2)) && (b_q >= B_W'(2));
    last_pair = (&a_q) && (&b_q);
    next_a    = a_q + 1'b1;
    next_b    = b_q;
    if (&a_q) begin
      next_a = A_W'(2);
      next_b = b_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q   <= StIdle;
      mode_q    <= 1'b0;
      target_q  <= '0;
      a_q       <= '0;
      b_q       <= '0;
      mcand_q   <= '0;
      mplier_q  <= '0;
      acc_q     <= '0;
      cnt_q     <= '0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      sat_q     <= 1'b0;
      found_a_q <= '0;
      found_b_q <= '0;
    end else begin
      case (state_q)
        StIdle: begin
          done_q <= 1'b0;
          if (start) begin
            mode_q    <= mode;
            target_q  <= target;
            acc_q     <= '0;
            cnt_q     <= CntW'(B_W);
            sat_q     <= 1'b0;
            found_a_q <= '0;
            found_b_q <= '0;
            busy_q    <= 1'b1;
            state_q   <= StMul;
            if (mode) begin
              a_q      <= A_W'(2);
              b_q      <= B_W'(2);
              mcand_q  <= P_W'(2);
              mplier_q <= B_W'(2);
            end else begin
              a_q      <= a;
              b_q      <= b;
              mcand_q  <= P_W'(a);
              mplier_q <= b;
            end
          end
        end

        StMul: begin
          if (mode_q && abort) begin
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
            state_q <= StDone;
          end else begin
            if (mplier_q[0]) acc_q <= acc_q + mcand_q;
            mcand_q  <= mcand_q << 1;
            mplier_q <= mplier_q >> 1;
            cnt_q    <= cnt_q - 1'b1;
            if (cnt_q == CntW'(1)) state_q <= StCmp;
          end
        end

        StCmp: begin
          if (mode_q && abort) begin
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
            state_q <= StDone;
          end else if (!mode_q || hit || last_pair) begin
            sat_q     <= hit;
            found_a_q <= hit ? a_q : '0;
            found_b_q <= hit ? b_q : '0;
            busy_q    <= 1'b0;
            done_q    <= 1'b1;
            state_q   <= StDone;
          end else begin
            // Miss: load the next pair straight back into the multiplier.
            a_q      <= next_a;
            b_q      <= next_b;
            mcand_q  <= P_W'(next_a);
            mplier_q <= next_b;
            acc_q    <= '0;
            cnt_q    <= CntW'(B_W);
            state_q  <= StMul;
          end
        end

        StDone: begin
          done_q  <= 1'b0;
          state_q <= StIdle;
        end

        default: state_q <= StIdle;
      endcase
    end
  end

  assign busy    = busy_q;
  assign done    = done_q;
  assign sat     = sat_q;
  assign found_a = found_a_q;
  assign found_b = found_b_q;

endmodule

// File: tb/tb_multiplier_factor_seq.sv
// Randomised bench for multiplier_factor_seq against an arithmetic model of the pair search.
module tb_multiplier_factor_seq;

  localparam int unsigned A_W = 7;
  localparam int unsigned B_W = 4;
  localparam int unsigned P_W = A_W + B_W;

  logic           clk = 1'b0;
  logic           rst_n = 1'b0;
  logic           start = 1'b0;
  logic           mode = 1'b0;
  logic [A_W-1:0] a = '0;
  logic [B_W-1:0] b = '0;
  logic [P_W-1:0] target = '0;
  logic           abort = 1'b0;
  logic           busy, done, sat;
  logic [A_W-1:0] found_a;
  logic [B_W-1:0] found_b;

  int unsigned n_checks = 0;
  int unsigned n_errors = 0;

  multiplier_factor_seq #(.A_W(A_W), .B_W(B_W)) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .start   (start),
    .mode    (mode),
    .a       (a),
    .b       (b),
    .target  (target),
    .abort   (abort),
    .busy    (busy),
    .done    (done),
    .sat     (sat),
    .found_a (found_a),
    .found_b (found_b)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Reference: scan b outer, a inner, counting pairs until a nontrivial match.
  task automatic model_search(input int unsigned t, output bit hit, output int unsigned fa,
                              output int unsigned fb, output int unsigned n);
    hit = 0; fa = 0; fb = 0; n = 0;
    for (int unsigned bb = 2; bb < (1 << B_W); bb++) begin
      for (int unsigned aa = 2; aa < (1 << A_W); aa++) begin
        n++;
        if (aa * bb == t) begin
          hit = 1; fa = aa; fb = bb;
          return;
        end
      end
    end
  endtask

  // Start an operation at edge 0 and return the cycle number in which done is seen.
  task automatic run_op(input logic m, input int unsigned av, input int unsigned bv,
                        input int unsigned tv, input int unsigned abort_cyc,
                        output int unsigned cyc);
    mode = m; a = A_W'(av); b = B_W'(bv); target = P_W'(tv); start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    // Scramble inputs: an operation in flight must not see them.
    mode = ~m; a = A_W'($urandom); b = B_W'($urandom); target = P_W'($urandom);
    check("busy_after_start", busy, 1);
    cyc = 1;
    while (!done && cyc < 10000) begin
      if (abort_cyc != 0 && cyc == abort_cyc) abort = 1'b1;
      start = ($urandom_range(0, 7) == 0);
      @(posedge clk); #1;
      abort = 1'b0; start = 1'b0; cyc++;
    end
    if (!done) check("done_timeout", 0, 1);
    else       check("busy_in_done", busy, 0);
  endtask

  task automatic check_result(input string tag, input int unsigned cyc,
                              input int unsigned exp_cyc, input bit exp_sat,
                              input int unsigned exp_a, input int unsigned exp_b);
    check({tag, "_cycle"}, cyc, exp_cyc);
    check({tag, "_sat"}, sat, exp_sat);
    check({tag, "_found_a"}, found_a, exp_a);
    check({tag, "_found_b"}, found_b, exp_b);
    // A start during the done cycle must be dropped.
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    check({tag, "_start_in_done_ignored"}, busy, 0);
    check({tag, "_done_one_cycle"}, done, 0);
    check({tag, "_sat_held"}, sat, exp_sat);
  endtask

  initial begin
    int unsigned cyc, fa, fb, n, av, bv, tv, pa, pb;
    bit hit;

    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_sat", sat, 0);
    check("rst_found_a", found_a, 0);
    check("rst_found_b", found_b, 0);
    rst_n = 1'b1;
    @(posedge clk); #1;

    run_op(1'b0, 17, 13, 221, 0, cyc);
    check_result("chk_17x13", cyc, 6, 1, 17, 13);

    // Reset from idle must clear a held result.
    rst_n = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    check("idle_rst_sat", sat, 0);
    check("idle_rst_found_a", found_a, 0);

    run_op(1'b0, 227, 1, 227, 0, cyc);
    check_result("chk_b1", cyc, 6, 0, 0, 0);

    // Random CHECKs, about half constructed to hit.
    for (int i = 0; i < 12; i++) begin
      av = $urandom_range(0, (1 << A_W) - 1);
      bv = $urandom_range(0, (1 << B_W) - 1);
      tv = ($urandom_range(0, 1) == 1) ? av * bv : $urandom_range(0, (1 << P_W) - 1);
      hit = (av * bv == tv) && av >= 2 && bv >= 2;
      run_op(1'b0, av, bv, tv, 0, cyc);
      check_result("chk_rand", cyc, 6, hit, hit ? av : 0, hit ? bv : 0);
    end

    model_search(221, hit, fa, fb, n);
    run_op(1'b1, 0, 0, 221, 0, cyc);
    check_result("srch_221", cyc, n * (B_W + 1) + 1, hit, fa, fb);

    model_search(227, hit, fa, fb, n);
    run_op(1'b1, 0, 0, 227, 0, cyc);
    check_result("srch_227", cyc, n * (B_W + 1) + 1, hit, fa, fb);

    run_op(1'b1, 0, 0, 221, 100, cyc);
    check_result("srch_abort", cyc, 101, 0, 0, 0);

    // Random SEARCHes, mostly built from a real product so the hit path is exercised.
    for (int i = 0; i < 4; i++) begin
      pa = $urandom_range(0, (1 << A_W) - 1);
      pb = $urandom_range(0, (1 << B_W) - 1);
      tv = ($urandom_range(0, 3) != 0) ? pa * pb : $urandom_range(0, (1 << P_W) - 1);
      model_search(tv, hit, fa, fb, n);
      run_op(1'b1, 0, 0, tv, 0, cyc);
      check_result("srch_rand", cyc, n * (B_W + 1) + 1, hit, fa, fb);
    end

    // Abort is ignored in CHECK mode.
    run_op(1'b0, 9, 7, 63, 3, cyc);
    check_result("chk_abort_ignored", cyc, 6, 1, 9, 7);

    // Reset in the middle of a CHECK multiply.
    mode = 1'b0; a = 7'd17; b = 4'd13; target = 11'd221; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    check("midmul_rst_busy", busy, 0);
    check("midmul_rst_done", done, 0);
    check("midmul_rst_sat", sat, 0);
    check("midmul_rst_found", {found_a, found_b}, 0);
    repeat (3) @(posedge clk);
    #1;
    check("midmul_rst_stays_idle", busy, 0);

    run_op(1'b0, 17, 13, 221, 0, cyc);
    check_result("post_rst_17x13", cyc, 6, 1, 17, 13);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
